// File: rtl/alu_seq_if.sv
// alu_seq_if: operand/result handshake bundle between operand fetch, the ALU and writeback
interface alu_seq_if #(
  parameter int N = 4
);
  logic         flush_i;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [N-1:0] a_i;
  logic [N-1:0] b_i;
  logic [2:0]   opcode_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [N-1:0] result_o;
  logic [3:0]   ALUFlags;
  modport slave (
    input  flush_i, in_valid_i, a_i, b_i, opcode_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, ALUFlags
  );
  modport master (
    output flush_i, in_valid_i, a_i, b_i, opcode_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, ALUFlags
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: handshaked N-bit ALU with registered NZCV flags and an iterative shift-add multiplier
module alu_seq #(
  parameter int N = 4
) (
  input logic      clk_i,
  input logic      rst_ni,
  alu_seq_if.slave bus
);
  localparam int SHW = $clog2(N);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t           state, state_nx;
  logic [N-1:0]     a, b, alu_r, mplier, result_q;
  logic [2:0]       op;
  logic [SHW-1:0]   s, cnt;
  logic [N:0]       sum, shl, shr;
  logic [2*N-1:0]   mcand, acc, acc_nx;
  logic [3:0]       alu_f, mul_f, flags_q;
  logic             alu_c, alu_v, accept, last;
  assign a = bus.a_i;
  assign b = bus.b_i;
  assign op = bus.opcode_i;
  assign s = bus.b_i[SHW-1:0];
  assign accept = bus.in_valid_i && state == IDLE;
  assign last = state == MUL && cnt == SHW'(N - 1);
  assign bus.in_ready_o = state == IDLE;
  assign bus.out_valid_o = state == DONE;
  assign bus.result_o = result_q;
  assign bus.ALUFlags = flags_q;
  // single-cycle result; SUB reuses the adder as a + ~b + 1, shifts carry the last bit out in an extra position
  always_comb begin
    sum = {1'b0, a} + {1'b0, (op[0] ? ~b : b)} + (N + 1)'(op[0]);
    shl = {1'b0, a} << s;
    shr = {a, 1'b0} >> s;
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (op)
      3'b000: begin
        alu_r = sum[N-1:0];
        alu_c = sum[N];
        alu_v = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
      end
      3'b001: begin
        alu_r = sum[N-1:0];
        alu_c = sum[N];
        alu_v = (a[N-1] != b[N-1]) && (sum[N-1] != a[N-1]);
      end
      3'b010: alu_r = a & b;
      3'b011: alu_r = a | b;
      3'b100: alu_r = a ^ b;
      3'b101: begin
        alu_r = shl[N-1:0];
        alu_c = shl[N];
      end
      3'b110: begin
        alu_r = shr[N:1];
        alu_c = shr[0];
      end
      default: alu_r = '0;
    endcase
    alu_f = {alu_r[N-1], alu_r == '0, alu_c, alu_v};
  end
  // one multiplier bit per cycle, LSB first; flags come from the final accumulated product
  always_comb begin
    acc_nx = acc + (mplier[0] ? mcand : '0);
    mul_f = {acc_nx[N-1], acc_nx[N-1:0] == '0, |acc_nx[2*N-1:N], |acc_nx[2*N-1:N]};
  end
  // state register
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= IDLE;
    else state <= state_nx;
  // next state; flush overrides both accept and pop
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = op == 3'b111 ? MUL : DONE;
      MUL: if (last) state_nx = DONE;
      DONE: if (bus.out_ready_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (bus.flush_i) state_nx = IDLE;
  end
  // operand capture, multiplier iteration and result/flag registers
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      result_q <= '0;
      flags_q <= '0;
      mcand <= '0;
      mplier <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (!bus.flush_i) begin
      if (accept && op == 3'b111) begin
        mcand <= {{N{1'b0}}, a};
        mplier <= b;
        acc <= '0;
        cnt <= '0;
      end else if (accept) begin
        result_q <= alu_r;
        flags_q <= alu_f;
      end else if (state == MUL) begin
        acc <= acc_nx;
        mcand <= mcand << 1;
        mplier <= mplier >> 1;
        cnt <= cnt + 1'b1;
        if (last) begin
          result_q <= acc_nx[N-1:0];
          flags_q <= mul_f;
        end
      end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors with hand-computed results for alu_seq at N=4
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int pops = 0;
  alu_seq_if #(.N(4)) bus ();
  alu_seq #(.N(4)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) if (rst_n && bus.out_valid_o && bus.out_ready_i) pops++;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    bus.opcode_i = op;
    bus.a_i = a;
    bus.b_i = b;
    bus.in_valid_i = 1'b1;
    tick();
    bus.in_valid_i = 1'b0;
  endtask
  task automatic op1(input string tag, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                     input logic [3:0] er, input logic [3:0] ef);
    issue(op, a, b);
    check({tag, ".valid"}, 8'(bus.out_valid_o), 8'd1);
    check({tag, ".res"}, 8'(bus.result_o), 8'(er));
    check({tag, ".flags"}, 8'(bus.ALUFlags), 8'(ef));
    tick();
    check({tag, ".popped"}, 8'(bus.out_valid_o), 8'd0);
  endtask
  task automatic mul_op(input string tag, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] er, input logic [3:0] ef);
    issue(3'b111, a, b);
    bus.a_i = ~a;
    bus.b_i = ~b;
    for (int i = 0; i < 4; i++) begin
      check({tag, ".busy"}, 8'(bus.in_ready_o), 8'd0);
      check({tag, ".early"}, 8'(bus.out_valid_o), 8'd0);
      tick();
    end
    check({tag, ".valid"}, 8'(bus.out_valid_o), 8'd1);
    check({tag, ".res"}, 8'(bus.result_o), 8'(er));
    check({tag, ".flags"}, 8'(bus.ALUFlags), 8'(ef));
    tick();
    check({tag, ".popped"}, 8'(bus.out_valid_o), 8'd0);
  endtask
  initial begin
    logic [2:0] bop [4] = '{3'b000, 3'b001, 3'b100, 3'b101};
    logic [3:0] ba [4] = '{4'h3, 4'h5, 4'hA, 4'h1};
    logic [3:0] bb [4] = '{4'h4, 4'h7, 4'h6, 4'h2};
    logic [3:0] br [4] = '{4'h7, 4'hE, 4'hC, 4'h4};
    logic [3:0] bf [4] = '{4'b0000, 4'b1000, 4'b1000, 4'b0000};
    int p0;
    bus.flush_i = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.a_i = '0;
    bus.b_i = '0;
    bus.opcode_i = '0;
    bus.out_ready_i = 1'b1;
    #12;
    check("rst.valid", 8'(bus.out_valid_o), 8'd0);
    check("rst.res", 8'(bus.result_o), 8'd0);
    check("rst.flags", 8'(bus.ALUFlags), 8'd0);
    check("rst.ready", 8'(bus.in_ready_o), 8'd1);
    rst_n = 1'b1;
    tick();
    op1("add7_1", 3'b000, 4'h7, 4'h1, 4'h8, 4'b1001);
    op1("sub3_3", 3'b001, 4'h3, 4'h3, 4'h0, 4'b0110);
    op1("sub2_3", 3'b001, 4'h2, 4'h3, 4'hF, 4'b1000);
    op1("addF_1", 3'b000, 4'hF, 4'h1, 4'h0, 4'b0110);
    op1("add8_8", 3'b000, 4'h8, 4'h8, 4'h0, 4'b0111);
    op1("and", 3'b010, 4'hC, 4'hA, 4'h8, 4'b1000);
    op1("or", 3'b011, 4'h5, 4'hA, 4'hF, 4'b1000);
    op1("xor", 3'b100, 4'hF, 4'hF, 4'h0, 4'b0100);
    op1("lsl9_1", 3'b101, 4'h9, 4'h1, 4'h2, 4'b0010);
    op1("lsl3_3", 3'b101, 4'h3, 4'h3, 4'h8, 4'b1010);
    op1("lsr8_3", 3'b110, 4'h8, 4'h3, 4'h1, 4'b0000);
    op1("lsrB_0", 3'b110, 4'hB, 4'h0, 4'hB, 4'b1000);
    op1("lsrB_2", 3'b110, 4'hB, 4'h2, 4'h2, 4'b0010);
    mul_op("mul5_3", 4'h5, 4'h3, 4'hF, 4'b1000);
    mul_op("mul5_4", 4'h5, 4'h4, 4'h4, 4'b0011);
    mul_op("mulF_F", 4'hF, 4'hF, 4'h1, 4'b0011);
    mul_op("mul0_9", 4'h0, 4'h9, 4'h0, 4'b0100);
    bus.out_ready_i = 1'b0;
    issue(3'b000, 4'h7, 4'h1);
    bus.opcode_i = 3'b000;
    bus.a_i = 4'h1;
    bus.b_i = 4'h1;
    bus.in_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp.valid", 8'(bus.out_valid_o), 8'd1);
      check("bp.res", 8'(bus.result_o), 8'h8);
      check("bp.flags", 8'(bus.ALUFlags), 8'b1001);
      check("bp.ready", 8'(bus.in_ready_o), 8'd0);
    end
    bus.out_ready_i = 1'b1;
    tick();
    check("bp.pop", 8'(bus.out_valid_o), 8'd0);
    check("bp.noacc", 8'(bus.in_ready_o), 8'd1);
    tick();
    bus.in_valid_i = 1'b0;
    check("bp.next.valid", 8'(bus.out_valid_o), 8'd1);
    check("bp.next.res", 8'(bus.result_o), 8'h2);
    check("bp.next.flags", 8'(bus.ALUFlags), 8'b0000);
    tick();
    check("bp.next.pop", 8'(bus.out_valid_o), 8'd0);
    issue(3'b111, 4'h5, 4'h3);
    tick();
    rst_n = 1'b0;
    #1;
    check("arst.valid", 8'(bus.out_valid_o), 8'd0);
    check("arst.res", 8'(bus.result_o), 8'd0);
    check("arst.flags", 8'(bus.ALUFlags), 8'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("arst.quiet", 8'(bus.out_valid_o), 8'd0);
    end
    op1("post_rst", 3'b000, 4'h7, 4'h1, 4'h8, 4'b1001);
    issue(3'b111, 4'h5, 4'h3);
    bus.flush_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    check("flush.ready", 8'(bus.in_ready_o), 8'd1);
    for (int i = 0; i < 6; i++) begin
      check("flush.nopulse", 8'(bus.out_valid_o), 8'd0);
      tick();
    end
    check("flush.keep.res", 8'(bus.result_o), 8'h8);
    check("flush.keep.flags", 8'(bus.ALUFlags), 8'b1001);
    bus.out_ready_i = 1'b0;
    issue(3'b010, 4'h6, 4'h3);
    bus.flush_i = 1'b1;
    bus.in_valid_i = 1'b1;
    tick();
    bus.flush_i = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.out_ready_i = 1'b1;
    check("flushd.valid", 8'(bus.out_valid_o), 8'd0);
    check("flushd.res", 8'(bus.result_o), 8'h2);
    check("flushd.ready", 8'(bus.in_ready_o), 8'd1);
    p0 = pops;
    for (int i = 0; i < 4; i++) begin
      bus.opcode_i = bop[i];
      bus.a_i = ba[i];
      bus.b_i = bb[i];
      bus.in_valid_i = 1'b1;
      tick();
      check("b2b.valid", 8'(bus.out_valid_o), 8'd1);
      check("b2b.res", 8'(bus.result_o), 8'(br[i]));
      check("b2b.flags", 8'(bus.ALUFlags), 8'(bf[i]));
      if (i < 3) begin
        bus.opcode_i = bop[i + 1];
        bus.a_i = ba[i + 1];
        bus.b_i = bb[i + 1];
      end else bus.in_valid_i = 1'b0;
      tick();
    end
    tick();
    tick();
    check("b2b.count", 8'(pops - p0), 8'd4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
